multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing the shared MIPS datapath (one ALU, one register file, PC/IR/MDR regs) over
//  multiple cycles per instruction. Sits beside the datapath in place of the single-cycle decoder.
//  Issues instruction/data memory strobes, waits on ready handshakes, flags a stuck memory via a watchdog.
//  Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, ori 001101, xori 001110, j 000010.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles waiting on i_ready/d_ready in one state before entering ERR (1..255)
// PORTS
//  clk          in   1  clock; all state updates on rising edge
//  rst          in   1  synchronous reset, active-high
//  Opcode       in   6  IR[31:26], valid from DECODE onward
//  i_ready      in   1  instruction memory data valid / access done
//  d_ready      in   1  data memory access done
//  i_read       out  1  instruction fetch strobe
//  d_read       out  1  data memory read strobe
//  d_write      out  1  data memory write strobe
//  IRWrite      out  1  load IR from instruction memory
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if branch condition true
//  BranchNe     out  1  condition select: 0 = zero flag (beq), 1 = !zero (bne)
//  PCSource     out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  ALUSrcA      out  1  0 PC, 1 rs register
//  ALUSrcB      out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  ALUop        out  2  00 add, 01 sub, 10 use funct, 11 immediate-logic (ALU decodes Opcode)
//  RegDst       out  1  1 rd, 0 rt
//  MemtoReg     out  1  1 MDR, 0 ALUOut
//  RegWrite     out  1  register file write enable
//  err          out  1  sticky: memory timeout or illegal opcode
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 RWB=7 BRANCH=8 JUMP=9 IEXEC=10 IWB=11 ERR=15.
//  Reset: state=FETCH, watchdog=0, err=0. Every output not listed for a state is 0; on the reset cycle all outputs 0.
//  FETCH: i_read=1, ALUSrcA=0, ALUSrcB=01, ALUop=00. IRWrite=PCWrite=1 ONLY in a cycle with i_ready=1
//   (ready-gated, the sole non-Moore outputs); then ->DECODE. Otherwise stay.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target precompute). Next by Opcode:
//   lw/sw->MEMADR, R->EXEC, beq/bne->BRANCH, j->JUMP, addi/ori/xori->IEXEC, other->ERR.
//  MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. lw->MEMRD, sw->MEMWR.
//  MEMRD: d_read=1 until d_ready -> MEMWB. MEMWR: d_write=1 until d_ready -> FETCH.
//  MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10 -> RWB. RWB: RegDst=1, RegWrite=1 -> FETCH.
//  IEXEC: ALUSrcA=1, ALUSrcB=10, ALUop=00 for addi, 11 for ori/xori -> IWB. IWB: RegDst=0, RegWrite=1 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, BranchNe=(Opcode==bne) -> FETCH.
//  JUMP: PCWrite=1, PCSource=10 -> FETCH.
//  Opcode is sampled combinationally in DECODE/MEMADR/IEXEC/BRANCH; IR is stable there.
//  Latency (zero wait): R/addi/ori/xori 4 cyc, lw 5, sw 4, beq/bne 3, j 3.
//  Watchdog: 8-bit counter, increments each cycle in FETCH/MEMRD/MEMWR with ready=0, clears on any state change.
//   When counter==MEM_TIMEOUT-1 and ready still 0 -> ERR next cycle. ready=1 on that same cycle wins (normal transition).
//  ERR: all strobes/enables 0, err=1; held until rst. Illegal opcode also reaches ERR via DECODE.
//  rst mid-instruction (incl. mid memory wait): next cycle FETCH, strobes drop; no partial RegWrite/PCWrite.
//  Ready arriving while not requested is ignored.
// TESTING
//  rst, i_ready=1, Opcode=000000 -> states 0,1,6,7,0; RegWrite=1,RegDst=1 only in RWB; one PCWrite per instr.
//  lw, d_ready held 0 for 3 cycles -> MEMRD for 4 cycles with d_read=1, then MEMWB with MemtoReg=1,RegWrite=1.
//  bne -> BRANCH with PCWriteCond=1,BranchNe=1,PCSource=01,ALUop=01; beq same with BranchNe=0; 3 cycles total.
//  MEM_TIMEOUT=4, i_ready=0 forever -> FETCH for exactly 4 cycles, then ERR, err=1 until rst; rst -> FETCH, err=0.
//  Opcode=111111 in DECODE -> ERR next cycle, no RegWrite/PCWrite/d_write ever asserted afterwards.
//  rst asserted in MEMWR with d_ready=0 -> next cycle state=0, d_write=0, watchdog=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared datapath per instruction,
// handshakes with instruction/data memory and traps stuck memory or bad opcodes.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       i_ready,
  input  logic       d_ready,
  output logic       i_read,
  output logic       d_read,
  output logic       d_write,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       err,
  output logic [3:0] state
);

  localparam int unsigned WD_W = 8;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_ERR    = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  logic [3:0]      state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;

  // State and watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next state; the watchdog counts only while a memory wait stays in place
  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    case (state_q)
      S_FETCH: begin
        if (i_ready)               state_d = S_DECODE;
        else if (wd_q == WD_LAST)  state_d = S_ERR;
        else                       wd_d    = wd_q + WD_W'(1);
      end
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_EXEC;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          OP_ADDI, OP_ORI, OP_XORI: state_d = S_IEXEC;
          default:                  state_d = S_ERR;
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_LW)      state_d = S_MEMRD;
        else if (Opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_ERR;
      end
      S_MEMRD, S_MEMWR: begin
        if (d_ready)              state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        else if (wd_q == WD_LAST) state_d = S_ERR;
        else                      wd_d    = wd_q + WD_W'(1);
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  // Moore output decode; IRWrite/PCWrite in FETCH follow i_ready, everything is quiet during rst
  always_comb begin
    i_read      = 1'b0;
    d_read      = 1'b0;
    d_write     = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    err         = 1'b0;
    state       = 4'd0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          i_read  = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = i_ready;
          PCWrite = i_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: d_read  = 1'b1;
        S_MEMWR: d_write = 1'b1;
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUop   = 2'b10;
        end
        S_RWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUop   = (Opcode == OP_ADDI) ? 2'b00 : 2'b11;
        end
        S_IWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUop       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          BranchNe    = (Opcode == OP_BNE);
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ERR:   err = 1'b1;
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected per-cycle
// output vector, a monitor on the falling edge pops and compares.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic       i_ready = 1'b0;
  logic       d_ready = 1'b0;
  logic       i_read, d_read, d_write, IRWrite, PCWrite, PCWriteCond, BranchNe;
  logic [1:0] PCSource, ALUSrcB, ALUop;
  logic       ALUSrcA, RegDst, MemtoReg, RegWrite, err;
  logic [3:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [21:0] exp_q[$];
  string       name_q[$];

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .i_ready(i_ready), .d_ready(d_ready),
    .i_read(i_read), .d_read(d_read), .d_write(d_write), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .err(err),
    .state(state)
  );

  always #5 clk = ~clk;

  // Reference table of control outputs per state, written from the state descriptions
  function automatic logic [21:0] exp_vec(input logic r, input logic [3:0] st,
                                          input logic [5:0] op, input logic ir);
    logic       e_ird, e_drd, e_dwr, e_irw, e_pcw, e_pcc, e_bne, e_asa, e_rd, e_m2r, e_rw, e_err;
    logic [1:0] e_pcs, e_asb, e_aop;
    logic [3:0] e_st;
    {e_ird, e_drd, e_dwr, e_irw, e_pcw, e_pcc, e_bne, e_asa, e_rd, e_m2r, e_rw, e_err} = '0;
    e_pcs = 2'b00; e_asb = 2'b00; e_aop = 2'b00; e_st = 4'd0;
    if (!r) begin
      e_st = st;
      case (st)
        4'd0:  begin e_ird = 1'b1; e_asb = 2'b01; e_irw = ir; e_pcw = ir; end
        4'd1:  e_asb = 2'b11;
        4'd2:  begin e_asa = 1'b1; e_asb = 2'b10; end
        4'd3:  e_drd = 1'b1;
        4'd4:  begin e_m2r = 1'b1; e_rw = 1'b1; end
        4'd5:  e_dwr = 1'b1;
        4'd6:  begin e_asa = 1'b1; e_aop = 2'b10; end
        4'd7:  begin e_rd = 1'b1; e_rw = 1'b1; end
        4'd8:  begin e_asa = 1'b1; e_aop = 2'b01; e_pcc = 1'b1; e_pcs = 2'b01;
                     e_bne = (op == OP_BNE); end
        4'd9:  begin e_pcw = 1'b1; e_pcs = 2'b10; end
        4'd10: begin e_asa = 1'b1; e_asb = 2'b10; e_aop = (op == OP_ADDI) ? 2'b00 : 2'b11; end
        4'd11: e_rw = 1'b1;
        default: e_err = 1'b1;
      endcase
    end
    return {e_st, e_err, e_ird, e_drd, e_dwr, e_irw, e_pcw, e_pcc, e_bne, e_pcs,
            e_asa, e_asb, e_aop, e_rd, e_m2r, e_rw};
  endfunction

  // One clock of stimulus plus the state the DUT must be in during that clock
  task automatic step(input logic r, input logic [5:0] op, input logic ir,
                      input logic dr, input logic [3:0] st, input string nm);
    @(posedge clk);
    #1;
    rst = r; Opcode = op; i_ready = ir; d_ready = dr;
    exp_q.push_back(exp_vec(r, st, op, ir));
    name_q.push_back(nm);
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison
  initial begin
    logic [21:0] act, want;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        act  = {state, err, i_read, d_read, d_write, IRWrite, PCWrite, PCWriteCond,
                BranchNe, PCSource, ALUSrcA, ALUSrcB, ALUop, RegDst, MemtoReg, RegWrite};
        n_cmp++;
        if (act !== want) begin
          n_fail++;
          $display("FAIL %s: got state=%0d vec=%b, required state=%0d vec=%b",
                   nm, act[21:18], act, want[21:18], want);
        end
      end
    end
  end

  initial begin
    int guard;
    step(1, OP_R, 0, 0, 0, "reset");
    // R-type, zero wait
    step(0, OP_R, 1, 0, 0, "r_fetch");
    step(0, OP_R, 1, 1, 1, "r_decode");
    step(0, OP_R, 1, 1, 6, "r_exec");
    step(0, OP_R, 1, 1, 7, "r_rwb");
    // lw with three data wait cycles
    step(0, OP_LW, 1, 0, 0, "lw_fetch");
    step(0, OP_LW, 0, 1, 1, "lw_decode");
    step(0, OP_LW, 0, 0, 2, "lw_memadr");
    step(0, OP_LW, 0, 0, 3, "lw_wait0");
    step(0, OP_LW, 0, 0, 3, "lw_wait1");
    step(0, OP_LW, 0, 0, 3, "lw_wait2");
    step(0, OP_LW, 0, 1, 3, "lw_memrd_done");
    step(0, OP_LW, 0, 0, 4, "lw_memwb");
    // sw: ready arrives exactly on the last watchdog cycle and wins
    step(0, OP_SW, 1, 0, 0, "sw_fetch");
    step(0, OP_SW, 0, 0, 1, "sw_decode");
    step(0, OP_SW, 0, 1, 2, "sw_memadr");
    step(0, OP_SW, 0, 0, 5, "sw_wait0");
    step(0, OP_SW, 0, 0, 5, "sw_wait1");
    step(0, OP_SW, 0, 0, 5, "sw_wait2");
    step(0, OP_SW, 0, 1, 5, "sw_ready_at_limit");
    // branches and jump
    step(0, OP_BNE, 1, 0, 0, "bne_fetch");
    step(0, OP_BNE, 0, 0, 1, "bne_decode");
    step(0, OP_BNE, 0, 0, 8, "bne_branch");
    step(0, OP_BEQ, 1, 0, 0, "beq_fetch");
    step(0, OP_BEQ, 0, 0, 1, "beq_decode");
    step(0, OP_BEQ, 0, 0, 8, "beq_branch");
    step(0, OP_J, 1, 0, 0, "j_fetch");
    step(0, OP_J, 0, 0, 1, "j_decode");
    step(0, OP_J, 0, 0, 9, "j_jump");
    // immediate ops, xori after one fetch wait
    step(0, OP_ADDI, 1, 0, 0, "addi_fetch");
    step(0, OP_ADDI, 0, 0, 1, "addi_decode");
    step(0, OP_ADDI, 0, 0, 10, "addi_iexec");
    step(0, OP_ADDI, 0, 0, 11, "addi_iwb");
    step(0, OP_ORI, 1, 0, 0, "ori_fetch");
    step(0, OP_ORI, 0, 0, 1, "ori_decode");
    step(0, OP_ORI, 0, 0, 10, "ori_iexec");
    step(0, OP_ORI, 0, 0, 11, "ori_iwb");
    step(0, OP_XORI, 0, 0, 0, "xori_fetch_wait");
    step(0, OP_XORI, 1, 0, 0, "xori_fetch");
    step(0, OP_XORI, 0, 0, 1, "xori_decode");
    step(0, OP_XORI, 0, 0, 10, "xori_iexec");
    step(0, OP_XORI, 0, 0, 11, "xori_iwb");
    // reset during a fetch wait must clear the watchdog
    step(0, OP_R, 0, 0, 0, "fw_wait0");
    step(0, OP_R, 0, 0, 0, "fw_wait1");
    step(1, OP_R, 0, 0, 0, "fw_rst");
    step(0, OP_R, 0, 0, 0, "fw_post0");
    step(0, OP_R, 0, 0, 0, "fw_post1");
    step(0, OP_R, 0, 0, 0, "fw_post2");
    step(0, OP_R, 1, 0, 0, "fw_post3_ready");
    step(0, OP_R, 0, 0, 1, "fw_decode");
    step(0, OP_R, 0, 0, 6, "fw_exec");
    step(0, OP_R, 0, 0, 7, "fw_rwb");
    // fetch timeout: four FETCH cycles, then sticky ERR
    step(0, OP_R, 0, 0, 0, "to_fetch0");
    step(0, OP_R, 0, 0, 0, "to_fetch1");
    step(0, OP_R, 0, 0, 0, "to_fetch2");
    step(0, OP_R, 0, 0, 0, "to_fetch3");
    step(0, OP_R, 1, 1, 15, "to_err0");
    step(0, OP_R, 1, 1, 15, "to_err1");
    step(0, OP_R, 0, 0, 15, "to_err2");
    step(1, OP_R, 0, 0, 0, "to_rst");
    step(0, OP_R, 0, 0, 0, "to_after_rst");
    step(0, OP_R, 1, 0, 0, "ill_fetch");
    // illegal opcode
    step(0, OP_BAD, 1, 1, 1, "ill_decode");
    step(0, OP_BAD, 1, 1, 15, "ill_err0");
    step(0, OP_SW, 1, 1, 15, "ill_err1");
    step(0, OP_R, 1, 1, 15, "ill_err2");
    step(1, OP_R, 0, 0, 0, "ill_rst");
    // reset during a data write wait
    step(0, OP_SW, 1, 0, 0, "rw_fetch");
    step(0, OP_SW, 0, 0, 1, "rw_decode");
    step(0, OP_SW, 0, 0, 2, "rw_memadr");
    step(0, OP_SW, 0, 0, 5, "rw_memwr");
    step(1, OP_SW, 0, 0, 5, "rw_rst");
    step(0, OP_SW, 0, 0, 0, "rw_after_rst");
    step(0, OP_SW, 0, 0, 0, "rw_wait1");
    step(0, OP_SW, 0, 0, 0, "rw_wait2");
    step(0, OP_SW, 1, 0, 0, "rw_wait3_ready");
    step(0, OP_SW, 0, 0, 1, "rw_decode2");
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
